// File: rtl/memory_responder_pkg.sv
// memrsp_pkg: shared types and constants for memory_responder.
//   state_t      FSM state encoding (IDLE, WAIT, LO, HI, DONE)
//   LO_LANE_*    bit range of the low byte lane within a 16-bit word (7:0)
//   HI_LANE_*    bit range of the high byte lane within a 16-bit word (15:8)
//   wait_cnt_w() width of the wait-state down-counter for a given wait count
package memrsp_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      LO   = 3'd2,
      HI   = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int LO_LANE_LSB = 0;
   localparam int LO_LANE_MSB = 7;
   localparam int HI_LANE_LSB = 8;
   localparam int HI_LANE_MSB = 15;

   // The counter is loaded with wait_cycles-1, so it needs to hold at most
   // wait_cycles-1; keep at least one bit so the vector is always legal.
   function automatic int wait_cnt_w(input int wait_cycles);
      return (wait_cycles < 2) ? 1 : $clog2(wait_cycles);
   endfunction

endpackage

// File: rtl/memory_responder_if.sv
// memory_responder_if: word request bus between a requester and the
// memory responder.
//   req    request strobe (requester -> responder)
//   wr_en  1 = write, 0 = read, captured with req
//   addr   byte address of the low byte, captured with req
//   wdata  write data, captured with req
//   ack    one-cycle completion pulse (responder -> requester)
//   busy   high from acceptance through the ack cycle
//   rdata  read data, valid with ack and held until the next read completes
//   err    error flag, valid with ack
//
// Handshake: a request is taken on a rising edge where req=1 and the
// responder is idle (busy=0). req while busy is dropped, not queued; a
// requester that still needs service keeps req high until it sees ack and
// the request is taken on the first idle edge after that.
interface memory_responder_if;
   logic        req;
   logic        wr_en;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic        busy;
   logic [15:0] rdata;
   logic        err;

   modport master (
      output req, wr_en, addr, wdata,
      input  ack, busy, rdata, err
   );

   modport slave (
      input  req, wr_en, addr, wdata,
      output ack, busy, rdata, err
   );
endinterface

// File: rtl/memory_responder_byte_ram.sv
// byte_ram: single-port synchronous byte RAM, 2^ADDR_W x 8.
//   clk    rising-edge clock
//   we     write enable for the addressed byte
//   addr   byte address (shared by read and write)
//   wdata  write byte
//   rdata  registered read byte (contents at addr before this edge's write)
// Contents are not reset.
module byte_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: serves one 16-bit read or write per request as two
// little-endian byte accesses (low byte at a, high byte at a+1 modulo the
// RAM size) on an internal byte_ram.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        memory_responder_if.slave request/response bus
//   dbg_state  current FSM state
// Parameters: ADDR_W (RAM holds 2^ADDR_W bytes), WAIT_CYCLES (wait states
// before the first byte access, 0 allowed).
// Optional feature macro MEMRSP_BOUNDS_EN: requests with address bits above
// ADDR_W set, or whose word would cross the top of the RAM, do not write,
// read back 16'h0000 and raise err with ack. Without it the upper address
// bits are ignored, the high byte wraps to address 0 and err is 0.
module memory_responder
   import memrsp_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   memory_responder_if.slave   bus,
   output state_t              dbg_state
);

   localparam int CNT_W     = wait_cnt_w(WAIT_CYCLES);
   localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] a_q;
   logic [ADDR_W-1:0] a_hi;
   logic [15:0]       wdata_q;
   logic              bad_q;
   logic [15:0]       rdata_q;
   logic              accept;
   logic              bad_in;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   assign accept = (state == IDLE) && bus.req;
   assign a_hi   = a_q + ADDR_W'(1);

`ifdef MEMRSP_BOUNDS_EN
   assign bad_in = ((bus.addr >> ADDR_W) != 16'h0000) ||
                   (bus.addr[ADDR_W-1:0] == {ADDR_W{1'b1}});
`else
   logic addr_hi_unused;
   assign addr_hi_unused = ^(bus.addr >> ADDR_W);
   assign bad_in         = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.req) state_nxt = (WAIT_CYCLES > 0) ? WAIT : LO;
         WAIT: if (wait_cnt == '0) state_nxt = LO;
         LO:   state_nxt = HI;
         HI:   state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port control. Writes use the address of the current byte state.
   // Reads are prefetched: the registered RAM output must already hold the
   // byte when the FSM sits in LO/HI, so the address for the state being
   // entered is presented one cycle early (straight from the bus when the
   // request is accepted with no wait states).
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = a_q;
      ram_wdata = wdata_q[LO_LANE_MSB:LO_LANE_LSB];
      if (wr_q && (state == LO || state == HI)) begin
         ram_we = !bad_q;
         if (state == HI) begin
            ram_addr  = a_hi;
            ram_wdata = wdata_q[HI_LANE_MSB:HI_LANE_LSB];
         end
      end else if (state == IDLE) begin
         ram_addr = bus.addr[ADDR_W-1:0];
      end else if (state_nxt == HI) begin
         ram_addr = a_hi;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         wr_q     <= 1'b0;
         a_q      <= '0;
         wdata_q  <= 16'h0000;
         bad_q    <= 1'b0;
         rdata_q  <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q     <= bus.wr_en;
            a_q      <= bus.addr[ADDR_W-1:0];
            wdata_q  <= bus.wdata;
            bad_q    <= bad_in;
            wait_cnt <= CNT_W'(WAIT_LOAD);
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
         // Writes leave rdata untouched; reads fill one lane per byte state.
         if (state == LO && !wr_q) begin
            rdata_q[LO_LANE_MSB:LO_LANE_LSB] <= bad_q ? 8'h00 : ram_rdata;
         end
         if (state == HI && !wr_q) begin
            rdata_q[HI_LANE_MSB:HI_LANE_LSB] <= bad_q ? 8'h00 : ram_rdata;
         end
      end
   end

   byte_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.ack   = (state == DONE);
   assign bus.busy  = (state != IDLE);
   assign bus.rdata = rdata_q;
`ifdef MEMRSP_BOUNDS_EN
   assign bus.err   = (state == DONE) && bad_q;
`else
   assign bus.err   = 1'b0;
`endif
   assign dbg_state = state;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed bench for memory_responder. Three instances
// share clock and reset: WAIT_CYCLES=1 (main), 0 and 3 (latency).
module tb_memory_responder;
  import memrsp_pkg::*;

`ifdef MEMRSP_BOUNDS_EN
  localparam logic BND = 1'b1;
`else
  localparam logic BND = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_responder_if bus ();
  memory_responder_if bus0 ();
  memory_responder_if bus3 ();
  state_t dbg, dbg0, dbg3;

  memory_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg));
  memory_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0));
  memory_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(dbg3));

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver task (main instance) ----------------
  // One complete request; checks latency, single-cycle ack, err and data.
  task automatic txn(input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic exp_err);
    int k;
    logic [15:0] exp;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.wr_en = wr;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    chk("busy_on_accept", bus.busy === 1'b1, bus.busy, 1'b1);
    k = 0;
    while (bus.ack !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ack_latency", k === 3, k, 3);
    chk("err", bus.err === exp_err, bus.err, exp_err);
    if (!wr) begin
      exp = exp_q.pop_front();
      chk("rdata", bus.rdata === exp, bus.rdata, exp);
      last_rd = exp;
    end else begin
      chk("rdata_hold", bus.rdata === last_rd, bus.rdata, last_rd);
    end
    @(negedge clk);
    chk("ack_one_cycle", bus.ack === 1'b0, bus.ack, 1'b0);
    chk("busy_release", bus.busy === 1'b0, bus.busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [11:0] ack_v, busy_v;
    logic [7:0]  ack0_v, busy0_v, ack3_v, busy3_v;

    bus.req = 1'b0;  bus.wr_en = 1'b0;  bus.addr = '0;  bus.wdata = '0;
    bus0.req = 1'b0; bus0.wr_en = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus3.req = 1'b0; bus3.wr_en = 1'b0; bus3.addr = '0; bus3.wdata = '0;
    last_rd = 16'h0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack === 1'b0, bus.ack, 1'b0);
    chk("rst_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("rst_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("rst_rdata", bus.rdata === 16'h0000, bus.rdata, 16'h0000);
    chk("rst_state", dbg === IDLE, dbg, IDLE);
    rst_n = 1'b1;

    // Basic write / read-back, little-endian.
    txn(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    txn(1'b1, 16'h0012, 16'hC0DE, 1'b0);
    exp_q.push_back(16'hBEEF); txn(1'b0, 16'h0010, 16'h0000, 1'b0);
    exp_q.push_back(16'hDEBE); txn(1'b0, 16'h0011, 16'h0000, 1'b0);

    // Top-of-RAM word: wraps without bounds checking, rejected with it.
    txn(1'b1, 16'h00FE, 16'h5566, 1'b0);
    txn(1'b1, 16'h0000, 16'h7788, 1'b0);
    txn(1'b1, 16'h00FF, 16'h1234, BND);
    exp_q.push_back(BND ? 16'h5566 : 16'h3466);
    txn(1'b0, 16'h00FE, 16'h0000, 1'b0);
    exp_q.push_back(BND ? 16'h7788 : 16'h7712);
    txn(1'b0, 16'h0000, 16'h0000, 1'b0);
    exp_q.push_back(BND ? 16'h0000 : 16'h7712);
    txn(1'b0, 16'h0100, 16'h0000, BND);

    // Req pulsed (as a write) during LO/HI/DONE of a read is ignored.
    @(negedge clk);
    bus.req = 1'b1; bus.wr_en = 1'b0; bus.addr = 16'h0010; bus.wdata = '0;
    @(posedge clk);
    ack_v = '0; busy_v = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ack_v[i]  = bus.ack;
      busy_v[i] = bus.busy;
      if (i == 0) bus.req = 1'b0;
      if (i >= 1 && i <= 3) begin
        bus.req = 1'b1; bus.wr_en = 1'b1; bus.wdata = 16'hDEAD;
      end
      if (i == 4) bus.req = 1'b0;
    end
    chk("ignored_ack_pattern", ack_v[8:0] === 9'h008, ack_v[8:0], 9'h008);
    chk("ignored_busy_pattern", busy_v[8:0] === 9'h00F, busy_v[8:0], 9'h00F);
    chk("ignored_rdata", bus.rdata === 16'hBEEF, bus.rdata, 16'hBEEF);
    last_rd = 16'hBEEF;
    exp_q.push_back(16'hBEEF); txn(1'b0, 16'h0010, 16'h0000, 1'b0);

    // Req held through DONE is taken at the next idle edge.
    @(negedge clk);
    bus.req = 1'b1; bus.wr_en = 1'b0; bus.addr = 16'h0012;
    @(posedge clk);
    ack_v = '0; busy_v = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ack_v[i]  = bus.ack;
      busy_v[i] = bus.busy;
      if (i == 5) bus.req = 1'b0;
    end
    chk("held_ack_pattern", ack_v === 12'h108, ack_v, 12'h108);
    chk("held_busy_pattern", busy_v === 12'h1EF, busy_v, 12'h1EF);
    chk("held_rdata", bus.rdata === 16'hC0DE, bus.rdata, 16'hC0DE);
    last_rd = 16'hC0DE;

    // Latency with WAIT_CYCLES=0 and 3: write, then read back.
    for (int it = 0; it < 2; it++) begin
      @(negedge clk);
      bus0.req = 1'b1; bus0.wr_en = (it == 0); bus0.addr = 16'h0020;
      bus0.wdata = 16'hA5C3;
      bus3.req = 1'b1; bus3.wr_en = (it == 0); bus3.addr = 16'h0020;
      bus3.wdata = 16'hA5C3;
      @(posedge clk);
      ack0_v = '0; busy0_v = '0; ack3_v = '0; busy3_v = '0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        ack0_v[i] = bus0.ack;  busy0_v[i] = bus0.busy;
        ack3_v[i] = bus3.ack;  busy3_v[i] = bus3.busy;
        if (i == 0) begin
          bus0.req = 1'b0;
          bus3.req = 1'b0;
        end
      end
      chk("w0_ack_pattern", ack0_v === 8'h04, ack0_v, 8'h04);
      chk("w0_busy_pattern", busy0_v === 8'h07, busy0_v, 8'h07);
      chk("w3_ack_pattern", ack3_v === 8'h20, ack3_v, 8'h20);
      chk("w3_busy_pattern", busy3_v === 8'h3F, busy3_v, 8'h3F);
      if (it == 1) begin
        chk("w0_rdata", bus0.rdata === 16'hA5C3, bus0.rdata, 16'hA5C3);
        chk("w3_rdata", bus3.rdata === 16'hA5C3, bus3.rdata, 16'hA5C3);
      end
    end

    // Reset asserted while in HI of a write: low byte written only.
    txn(1'b1, 16'h0030, 16'h1122, 1'b0);
    @(negedge clk);
    bus.req = 1'b1; bus.wr_en = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'h9ABC;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    k = 0;
    while (dbg !== HI && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("reach_hi", dbg === HI, dbg, HI);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", bus.ack === 1'b0, bus.ack, 1'b0);
    chk("async_rst_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("async_rst_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("async_rst_rdata", bus.rdata === 16'h0000, bus.rdata, 16'h0000);
    chk("async_rst_state", dbg === IDLE, dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 16'h0000;
    @(negedge clk);
    chk("state_after_release", dbg === IDLE, dbg, IDLE);
    exp_q.push_back(16'h11BC); txn(1'b0, 16'h0030, 16'h0000, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
